// File: rtl/alu_8bit.sv
// Registered 8-bit ALU for the execute stage: 16 operations on unsigned operands,
// result and a+b carry-out presented one clock after the operands are sampled.
module alu_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic [3:0] alu_sel,
  output logic [7:0] alu_out,
  output logic       alu_cout
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } alu_op_e;

  alu_op_e    op;
  logic [8:0] sum;
  logic [7:0] diff;
  logic [7:0] prod;
  logic [8:0] rem;
  logic [7:0] quo;
  logic [7:0] alu_out_d, alu_out_q;
  logic       alu_cout_d, alu_cout_q;

  // Carry-in is reserved: kept on the port but deliberately unused.
  logic cin_unused;
  assign cin_unused = cin;

  assign op   = alu_op_e'(alu_sel);
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign prod = a * b;

  // Restoring division unrolled into combinational logic. With b=0 every trial
  // subtraction succeeds, so the quotient naturally saturates to 8'hFF.
  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = 7; i >= 0; i--) begin
      rem = {rem[7:0], a[i]};
      if (rem >= {1'b0, b}) begin
        rem    = rem - {1'b0, b};
        quo[i] = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    alu_out_d  = 8'h00;
    alu_cout_d = sum[8];
    unique case (op)
      OP_ADD:  alu_out_d = sum[7:0];
      OP_SUB:  alu_out_d = diff;
      OP_MUL:  alu_out_d = prod;
      OP_DIV:  alu_out_d = quo;
      OP_SHL:  alu_out_d = {a[6:0], 1'b0};
      OP_SHR:  alu_out_d = {1'b0, a[7:1]};
      OP_ROL:  alu_out_d = {a[6:0], a[7]};
      OP_ROR:  alu_out_d = {a[0], a[7:1]};
      OP_AND:  alu_out_d = a & b;
      OP_OR:   alu_out_d = a | b;
      OP_XOR:  alu_out_d = a ^ b;
      OP_NOR:  alu_out_d = ~(a | b);
      OP_NAND: alu_out_d = ~(a & b);
      OP_XNOR: alu_out_d = ~(a ^ b);
      OP_GT:   alu_out_d = {7'd0, (a > b)};
      OP_EQ:   alu_out_d = {7'd0, (a == b)};
      default: alu_out_d = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q  <= 8'h00;
      alu_cout_q <= 1'b0;
    end else begin
      alu_out_q  <= alu_out_d;
      alu_cout_q <= alu_cout_d;
    end
  end

  assign alu_out  = alu_out_q;
  assign alu_cout = alu_cout_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Directed-vector bench for alu_8bit: table-driven sweeps and boundaries, plus
// hand-written reset, mid-stream reset and between-edge stability sequences.
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_cout;

  int n_vec  = 0;
  int n_fail = 0;

  alu_8bit dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_cout (alu_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic       cin;
    logic [7:0] exp_out;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] exp_out, input logic exp_cout);
    n_vec++;
    if (alu_out !== exp_out || alu_cout !== exp_cout) begin
      n_fail++;
      $display("FAIL %s: got out=%h cout=%b, expected out=%h cout=%b",
               name, alu_out, alu_cout, exp_out, exp_cout);
    end
  endtask

  // Drive inputs mid-cycle, then sample just after the capturing edge.
  task automatic apply(input logic r, input logic [7:0] va, input logic [7:0] vb,
                       input logic [3:0] vs, input logic vc);
    @(negedge clk);
    rst = r; a = va; b = vb; alu_sel = vs; cin = vc;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vs,
                         input logic vc, input logic [7:0] eo, input logic ec);
    vec_t v;
    v.a = va; v.b = vb; v.sel = vs; v.cin = vc; v.exp_out = eo; v.exp_cout = ec;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] sweep1 [16] = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                                8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    logic [7:0] sweep2 [16] = '{8'h00, 8'hEC, 8'h9C, 8'h18, 8'hEC, 8'h7B, 8'hED, 8'h7B,
                                8'h02, 8'hFE, 8'hFC, 8'h01, 8'hFD, 8'h03, 8'h01, 8'h00};

    for (int s = 0; s < 16; s++) add_vec(8'h0A, 8'h02, 4'(s), 1'b0, sweep1[s], 1'b0);
    for (int s = 0; s < 16; s++) add_vec(8'hF6, 8'h0A, 4'(s), 1'b0, sweep2[s], 1'b1);
    for (int s = 0; s < 16; s++) add_vec(8'hF6, 8'h0A, 4'(s), 1'b1, sweep2[s], 1'b1);
    add_vec(8'h37, 8'h00, 4'h3, 1'b0, 8'hFF, 1'b0);
    add_vec(8'h5A, 8'h5A, 4'hF, 1'b0, 8'h01, 1'b0);
    add_vec(8'h5A, 8'h5A, 4'hE, 1'b0, 8'h00, 1'b0);
    add_vec(8'h00, 8'h01, 4'h1, 1'b0, 8'hFF, 1'b0);
    add_vec(8'hFF, 8'hFF, 4'h2, 1'b0, 8'h01, 1'b1);
    add_vec(8'h81, 8'h00, 4'h6, 1'b0, 8'h03, 1'b0);
    add_vec(8'h81, 8'h00, 4'h7, 1'b0, 8'hC0, 1'b0);
    add_vec(8'hFF, 8'h10, 4'h3, 1'b0, 8'h0F, 1'b1);

    rst = 1'b1; a = 8'hFF; b = 8'h01; alu_sel = 4'h0; cin = 1'b0;

    // Reset held two cycles with an overflowing ADD presented.
    apply(1'b1, 8'hFF, 8'h01, 4'h0, 1'b0);
    check("reset_cycle1", 8'h00, 1'b0);
    apply(1'b1, 8'hFF, 8'h01, 4'h0, 1'b0);
    check("reset_cycle2", 8'h00, 1'b0);
    apply(1'b0, 8'hFF, 8'h01, 4'h0, 1'b0);
    check("reset_release", 8'h00, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(1'b0, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].cin);
      check($sformatf("vec%0d_sel%h", i, vecs[i].sel), vecs[i].exp_out, vecs[i].exp_cout);
    end

    // Mid-stream reset: one-cycle pulse between back-to-back ops.
    apply(1'b0, 8'h20, 8'h03, 4'h2, 1'b0);
    check("midrst_before", 8'h60, 1'b0);
    apply(1'b1, 8'hF0, 8'h20, 4'h0, 1'b0);
    check("midrst_pulse", 8'h00, 1'b0);
    apply(1'b0, 8'hF0, 8'h20, 4'h0, 1'b0);
    check("midrst_after", 8'h10, 1'b1);

    // Inputs changed between edges must not disturb the registered outputs.
    apply(1'b0, 8'h12, 8'h34, 4'h9, 1'b0);
    check("stable_capture", 8'h36, 1'b0);
    a = 8'hFF; b = 8'hFF; alu_sel = 4'h0;
    #2;
    check("stable_between_edges", 8'h36, 1'b0);
    @(posedge clk);
    #1;
    check("stable_next_edge", 8'hFE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
